// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Optional lap/freeze display is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam int SEC_U_MOD = 10;
   localparam int SEC_T_MOD = 6;
   localparam int MIN_U_MOD = 10;
   localparam int MIN_T_MOD = 6;

   // Modulus of cascade stage idx, least significant digit first.
   function automatic int digit_mod(input int idx);
      case (idx)
         0:       return SEC_U_MOD;
         1:       return SEC_T_MOD;
         2:       return MIN_U_MOD;
         default: return MIN_T_MOD;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counting stage: counts 0..MOD-1 when enabled, wraps to 0 and
// raises carry combinationally on the enabled terminal count.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output bcd_t q,
   output logic carry
);

   localparam bcd_t LAST = bcd_t'(MOD - 1);

   bcd_t q_q;
   bcd_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = (q_q == LAST) ? '0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = en && (q_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller driving a four-digit BCD MM:SS cascade.
// Define STOPWATCH_LAP_EN to add the lap input and frozen-display snapshot.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 10,
   parameter int PW       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        lap,
`endif
   output logic [15:0] digits,
   output logic        running,
   output logic        overflow
);

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          running_q, running_d;
   logic          overflow_q, overflow_d;
   logic          tick;
   logic          clr_digits;
   logic [3:0]    en;
   logic [3:0]    carry;
   logic [15:0]   live;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // clear is dropped in RUN; in IDLE/PAUSE it beats a simultaneous start_stop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!clear && start_stop) state_d = RUN;
         RUN:     if (start_stop)           state_d = PAUSE;
         PAUSE: begin
            if (clear)           state_d = IDLE;
            else if (start_stop) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tick       = (state_q == RUN) && (pre_q == PRE_LAST);
      clr_digits = clear && (state_q != RUN);
      running_d  = (state_d == RUN);
   end

   always_comb begin
      pre_d = pre_q;
      if (clr_digits) begin
         pre_d = '0;
      end else if (state_q == RUN) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
      end
      overflow_d = carry[3];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q      <= '0;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         running_q  <= running_d;
         overflow_q <= overflow_d;
      end
   end

   assign en[0] = tick;

   for (genvar i = 0; i < 4; i++) begin : g_digit
      if (i > 0) begin : g_chain
         assign en[i] = carry[i-1];
      end
      bcd_digit #(
         .MOD (digit_mod(i))
      ) u_digit (
         .clk   (clk),
         .rst   (rst),
         .en    (en[i]),
         .clr   (clr_digits),
         .q     (live[4*i +: 4]),
         .carry (carry[i])
      );
   end

`ifdef STOPWATCH_LAP_EN
   logic        freeze_q, freeze_d;
   logic [15:0] snap_q, snap_d;

   // Leaving RUN releases the freeze even if lap arrives on the same cycle.
   always_comb begin
      freeze_d = freeze_q;
      snap_d   = snap_q;
      if (clr_digits) begin
         freeze_d = 1'b0;
      end else if (state_q == RUN) begin
         if (start_stop) begin
            freeze_d = 1'b0;
         end else if (lap) begin
            if (freeze_q) begin
               freeze_d = 1'b0;
            end else begin
               freeze_d = 1'b1;
               snap_d   = live;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         freeze_q <= 1'b0;
         snap_q   <= '0;
      end else begin
         freeze_q <= freeze_d;
         snap_q   <= snap_d;
      end
   end

   assign digits = freeze_q ? snap_q : live;
`else
   assign digits = live;
`endif

   assign running  = running_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: elapsed-seconds reference model, per-scenario tasks.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int PW = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic        lap = 1'b0;
`endif
  logic [15:0] digits;
  logic        running;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: elapsed seconds and tick phase
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_phase = 0;
  int m_snap = 0;
  bit m_frozen = 1'b0;
  bit m_ovf = 1'b0;
  bit m_run = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .overflow   (overflow)
  );

  function automatic logic [15:0] exp_digits();
    int s;
    int mm;
    int ss;
    logic [3:0] d3, d2, d1, d0;
    s  = m_frozen ? m_snap : m_secs;
    mm = s / 60;
    ss = s % 60;
    d3 = 4'(mm / 10);
    d2 = 4'(mm % 10);
    d1 = 4'(ss / 10);
    d0 = 4'(ss % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_step(input bit ss, input bit cl, input bit lp, input bit r);
    bit tk;
    if (r) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_frozen = 0; m_snap = 0; m_ovf = 0;
    end else begin
      tk = (m_mode == M_RUN) && (m_phase == TD - 1);
      m_ovf = tk && (m_secs == 3599);
      if (m_mode == M_RUN && ss) m_frozen = 0;
      else if (m_mode == M_RUN && lp) begin
        if (m_frozen) m_frozen = 0;
        else begin m_frozen = 1; m_snap = m_secs; end
      end
      if (m_mode == M_RUN) begin
        m_phase = (m_phase + 1) % TD;
        if (tk) m_secs = (m_secs + 1) % 3600;
      end
      case (m_mode)
        M_IDLE: if (!cl && ss) m_mode = M_RUN;
        M_RUN:  if (ss) m_mode = M_PAUSE;
        default: begin
          if (cl) begin m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_frozen = 0; end
          else if (ss) m_mode = M_RUN;
        end
      endcase
    end
    m_run = (m_mode == M_RUN);
  endtask

  // one clock: inputs applied at negedge, model advanced at posedge, returns at next negedge
  task automatic cyc(input bit ss, input bit cl, input bit lp, input bit r);
    rst = r; start_stop = ss; clear = cl;
`ifdef STOPWATCH_LAP_EN
    lap = lp;
`endif
    @(posedge clk);
    model_step(ss, cl, lp, r);
    @(negedge clk);
    rst = 0; start_stop = 0; clear = 0;
`ifdef STOPWATCH_LAP_EN
    lap = 0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits cyc %0d got %h exp 0000", i, digits); end
      n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running cyc %0d got %b exp 0", i, running); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow cyc %0d got %b exp 0", i, overflow); end
    end
  endtask

  task automatic test_count();
    cyc(1, 0, 0, 0);
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL count_running_rise got %b exp 1", running); end
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL count_digits cyc %0d got %h exp %h", i, digits, exp_digits()); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL count_overflow cyc %0d got %b exp 0", i, overflow); end
    end
    n_tests++; if (digits !== 16'h0010) begin n_fail++; $display("FAIL count_40cyc got %h exp 0010", digits); end
  endtask

  task automatic test_overflow();
    int budget = 20000;
    while (!(m_secs == 3599 && m_phase == TD - 1) && budget > 0) begin
      cyc(0, 0, 0, 0);
      budget--;
      n_tests++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL ovf_run_digits got %h exp %h", digits, exp_digits()); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early_pulse got %b exp 0", overflow); end
    end
    n_tests++; if (budget == 0) begin n_fail++; $display("FAIL ovf_budget got timeout exp 59:59 reached"); end
    n_tests++; if (digits !== 16'h5959) begin n_fail++; $display("FAIL ovf_pre got %h exp 5959", digits); end
    cyc(0, 0, 0, 0);
    n_tests++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL ovf_wrap_digits got %h exp 0000", digits); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL ovf_running got %b exp 1", running); end
    cyc(0, 0, 0, 0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_width got %b exp 0", overflow); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL ovf_running_after got %b exp 1", running); end
  endtask

  task automatic test_pause_resume();
    int budget = 100;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    n_tests++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL pr_clear got %h exp 0000", digits); end
    cyc(1, 0, 0, 0);
    while (!(m_secs == 3 && m_phase == 1) && budget > 0) begin cyc(0, 0, 0, 0); budget--; end
    n_tests++; if (budget == 0) begin n_fail++; $display("FAIL pr_budget got timeout exp 00:03"); end
    cyc(1, 0, 0, 0);
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pr_paused_running got %b exp 0", running); end
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== 16'h0003) begin n_fail++; $display("FAIL pr_hold cyc %0d got %h exp 0003", i, digits); end
    end
    cyc(1, 0, 0, 0);
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL pr_resume_running got %b exp 1", running); end
    n_tests++; if (digits !== 16'h0003) begin n_fail++; $display("FAIL pr_resume0 got %h exp 0003", digits); end
    cyc(0, 0, 0, 0);
    n_tests++; if (digits !== 16'h0003) begin n_fail++; $display("FAIL pr_resume1 got %h exp 0003", digits); end
    cyc(0, 0, 0, 0);
    n_tests++; if (digits !== 16'h0004) begin n_fail++; $display("FAIL pr_resume2 got %h exp 0004", digits); end
  endtask

  task automatic test_ss_clear();
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL clr_in_run_running got %b exp 1", running); end
    n_tests++; if (digits !== exp_digits() || digits === 16'h0000) begin n_fail++; $display("FAIL clr_in_run_digits got %h exp %h", digits, exp_digits()); end
    cyc(1, 1, 0, 0);
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL both_run_running got %b exp 0", running); end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL both_run_hold got %h exp %h", digits, exp_digits()); end
    end
    cyc(1, 1, 0, 0);
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL both_pause_running got %b exp 0", running); end
    n_tests++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL both_pause_digits got %h exp 0000", digits); end
    cyc(1, 1, 0, 0);
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL both_idle_running got %b exp 0", running); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    int budget = 100;
    cyc(1, 0, 0, 0);
    while (!(m_secs == 5 && m_phase == 0) && budget > 0) begin cyc(0, 0, 0, 0); budget--; end
    n_tests++; if (budget == 0) begin n_fail++; $display("FAIL lap_budget got timeout exp 00:05"); end
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== 16'h0005) begin n_fail++; $display("FAIL lap_frozen cyc %0d got %h exp 0005", i, digits); end
    end
    cyc(0, 0, 1, 0);
    n_tests++; if (digits !== 16'h0010) begin n_fail++; $display("FAIL lap_release got %h exp 0010", digits); end
  endtask
`endif

  task automatic test_reset_midrun();
    if (!m_run) cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    n_tests++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_digits got %h exp 0000", digits); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL rst_mid_running got %b exp 0", running); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow got %b exp 0", overflow); end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < TD; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL rst_first_tick cyc %0d got %h exp %h", i, digits, exp_digits()); end
    end
    n_tests++; if (digits !== 16'h0001) begin n_fail++; $display("FAIL rst_first_tick_value got %h exp 0001", digits); end
  endtask

  task automatic test_random();
    bit ss, cl, lp, r;
    for (int i = 0; i < 4000; i++) begin
      ss = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 29) == 0);
      r  = ($urandom_range(0, 799) == 0);
`ifdef STOPWATCH_LAP_EN
      lp = ($urandom_range(0, 24) == 0);
`else
      lp = 1'b0;
`endif
      cyc(ss, cl, lp, r);
      n_tests++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL rand_digits cyc %0d got %h exp %h", i, digits, exp_digits()); end
      n_tests++; if (running !== m_run) begin n_fail++; $display("FAIL rand_running cyc %0d got %b exp %b", i, running, m_run); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow cyc %0d got %b exp %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_pause_resume();
    test_ss_clear();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
